// File: rtl/rom_stream_reader.sv
// ============================================================================
//  Module      : rom_stream_reader
//  Description : Sweeps a block of words out of a 1-cycle-latency synchronous
//                ROM and presents them as a valid/ready stream via a 2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_stream_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZERO  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               r_state;
    logic [2:0]               w_next;
    logic [ADDRESS_WIDTH-1:0] r_ptr;
    logic [ADDRESS_WIDTH:0]   r_remaining;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic [DATA_WIDTH-1:0]    r_mem_data [0:1];
    logic                     r_mem_last [0:1];
    logic                     r_rd_idx;
    logic                     r_wr_idx;
    logic [1:0]               r_cnt;

    logic                     w_pop;
    logic                     w_push;
    logic                     w_issue;
    logic                     w_head_last;
    logic [2:0]               w_occ;
    logic [ADDRESS_WIDTH:0]   w_rem_next;

    assign m_valid     = (r_cnt != 2'd0);
    assign w_pop       = m_valid & m_ready;
    assign w_push      = r_inflight;
    assign w_head_last = r_mem_last[r_rd_idx];
    // Occupancy after this cycle's pop; a new issue may only claim a free slot.
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == S_READ) && (r_remaining != '0) && (w_occ < 3'd2);
    assign w_rem_next  = r_remaining - (ADDRESS_WIDTH+1)'(w_issue);

    assign rom_addr = r_ptr;
    assign m_data   = m_valid ? r_mem_data[r_rd_idx] : '0;
    assign m_last   = m_valid & w_head_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (length == '0) ? S_ZERO : S_READ;
            // Zero-length sweep waits here one cycle so done lands two cycles after start.
            S_ZERO:  w_next = S_DONE;
            S_READ:  if (w_rem_next == '0) w_next = S_DRAIN;
            S_DRAIN: if (w_pop && w_head_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_READ:  busy = 1'b1;
            S_DRAIN: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr           <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_mem_data[0]   <= '0;
            r_mem_data[1]   <= '0;
            r_mem_last[0]   <= 1'b0;
            r_mem_last[1]   <= 1'b0;
            r_rd_idx        <= 1'b0;
            r_wr_idx        <= 1'b0;
            r_cnt           <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_ptr       <= base_addr;
                r_remaining <= length;
            end else if (w_issue) begin
                r_ptr       <= r_ptr + ADDRESS_WIDTH'(1);
                r_remaining <= w_rem_next;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == (ADDRESS_WIDTH+1)'(1));

            if (w_push) begin
                r_mem_data[r_wr_idx] <= rom_data;
                r_mem_last[r_wr_idx] <= r_inflight_last;
                r_wr_idx             <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ============================================================================
//  Module      : tb_rom_stream_reader
//  Description : Self-checking bench; a ROM array plus an expected-word queue
//                per sweep serve as the reference for the streamed output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic [DW-1:0] mem [DEPTH];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    rom_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready plus stray start pulses;
    // 2: ready low in cycles 5..9. abort > 0 leaves the sweep at that cycle.
    task automatic run_sweep(input int b, input int len, input int mode, input int abort);
        logic [DW-1:0] q[$];
        logic [DW-1:0] prev_data;
        logic [AW-1:0] ahead;
        logic          prev_last;
        bit            prev_stall;
        bit            fin;
        bit            exp_busy;
        bit            exp_done;
        int            cyc;
        int            fin_cyc;
        int            accepted;
        int            budget;
        q = {};
        for (int k = 0; k < len; k++) q.push_back(mem[(b + k) % DEPTH]);
        start      = 1'b1;
        base_addr  = AW'(b);
        length     = (AW+1)'(len);
        m_ready    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc        = 0;
        fin        = 1'b0;
        fin_cyc    = 0;
        accepted   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        budget     = 4 * len + 40;
        while (1) begin
            @(negedge clk);
            exp_busy = (len > 0) && (cyc >= 1) && !fin;
            exp_done = (len == 0) ? (cyc == 2) : (fin && (cyc == fin_cyc + 1));
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            if (cyc == 1 && len > 0) chk("first_addr", rom_addr, b % DEPTH);
            if (len == 0 || fin) chk("valid_idle", m_valid, 1'b0);
            if (mode == 0 && len > 0 && !fin)
                chk("valid_rate", m_valid, (cyc >= 3) && (cyc <= len + 2));
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (exp_busy) begin
                ahead = rom_addr - AW'(b) - AW'(accepted);
                chk("lookahead", ahead <= 2, 1'b1);
            end
            if (m_valid && q.size() > 0) begin
                chk("data", m_data, q[0]);
                chk("last", m_last, q.size() == 1);
            end else if (m_valid) begin
                chk("extra_word", m_valid, 1'b0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                accepted++;
                if (q.size() == 0 && !fin) begin
                    fin     = 1'b1;
                    fin_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (abort > 0 && cyc == abort) break;
            if ((len == 0) ? (cyc > 4) : (fin && cyc > fin_cyc + 3)) break;
            if (cyc > budget) begin
                chk("timeout", fin, 1'b1);
                break;
            end
            start     = (mode == 1 && (!fin || cyc <= fin_cyc + 1)) ? ($urandom_range(0, 3) == 0) : 1'b0;
            base_addr = AW'($urandom);
            length    = (AW+1)'($urandom);
            case (mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = !(cyc >= 5 && cyc <= 9);
                default: m_ready = 1'b1;
            endcase
        end
        start   = 1'b0;
        m_ready = 1'b1;
        if (abort == 0) chk("all_words", q.size(), 0);
    endtask

    initial begin
        logic [31:0] rnd;
        reset     = 1'b1;
        start     = 1'b0;
        m_ready   = 1'b1;
        base_addr = '0;
        length    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rnd    = $urandom;
            mem[i] = {rnd[19:0], 12'(i)};
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_addr", rom_addr, 12'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_sweep(0, 4, 0, 0);
        run_sweep(10, 8, 2, 0);
        run_sweep(4094, 4, 0, 0);
        run_sweep(5, 0, 0, 0);
        run_sweep(200, 30, 1, 0);

        run_sweep(100, 50, 1, 20);
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", m_valid, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_done", done, 1'b0);
        chk("post_rst_addr", rom_addr, 12'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("quiet_valid", m_valid, 1'b0);
            chk("quiet_busy", busy, 1'b0);
        end
        @(posedge clk);
        #1;
        run_sweep(0, 2, 0, 0);

        for (int i = 0; i < 3; i++) run_sweep($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1, 0);
        run_sweep($urandom_range(0, DEPTH - 1), DEPTH, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
